input_port_buffer: RTL and testbench

//  Per-input-port packet buffer of a MAZE mesh node, directly downstream of the pre-buffer router unit.

---
 rtl/maze_pkg.sv | 35 +++
 rtl/input_port_buffer_if.sv | 27 ++
 rtl/buf_fifo.sv | 60 ++++++
 rtl/input_port_buffer.sv | 78 +++++++
 tb/tb_input_port_buffer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/maze_pkg.sv
// Shared MAZE mesh definitions: route-request bit positions, packet types
// and the packed packet layout carried between node stages.
package maze_pkg;

    localparam int DIR_N = 0;
    localparam int DIR_W = 1;
    localparam int DIR_S = 2;
    localparam int DIR_E = 3;
    localparam int DIR_B = 4;

    localparam logic [1:0] PKT_UNI = 2'b00;
    localparam logic [1:0] PKT_COL = 2'b01;
    localparam logic [1:0] PKT_ROW = 2'b10;
    localparam logic [1:0] PKT_BC  = 2'b11;

    localparam int PLD_W_DEF = 32;
    localparam int HDR_W     = 14;

    typedef logic [4:0] route_t;

    typedef struct packed {
        logic [1:0]           pkt_type;
        logic [2:0]           src_x;
        logic [2:0]           src_y;
        logic [2:0]           tgt_x;
        logic [2:0]           tgt_y;
        logic [PLD_W_DEF-1:0] payload;
    } pkt_t;

    // True when this cycle's grants complete every branch of the head request.
    function automatic logic route_done(route_t head_req, route_t served, route_t gnt);
        return ((served | gnt) == head_req);
    endfunction

endpackage

// File: rtl/input_port_buffer_if.sv
// Handshake bundle between the router unit, the input buffer and the switch
// allocator: upstream push side plus the head request/grant side.
interface input_port_buffer_if #(
    parameter int PLD_W = 32
);
    import maze_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    route_t                 in_req;
    logic [HDR_W+PLD_W-1:0] in_pkt;
    route_t                 out_req;
    logic [HDR_W+PLD_W-1:0] out_pkt;
    route_t                 grant;

    // master: router unit + allocator side; slave: the buffer itself
    modport master (
        output in_valid, in_req, in_pkt, grant,
        input  in_ready, out_req, out_pkt
    );

    modport slave (
        input  in_valid, in_req, in_pkt, grant,
        output in_ready, out_req, out_pkt
    );

endinterface

// File: rtl/buf_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; read data is the head
// entry, presented combinationally from storage.
module buf_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_rd,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("buf_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

    assign w_wr_en = i_wr && !o_full;
    assign w_rd_en = i_rd && !o_empty;

    // Storage carries no reset: validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/input_port_buffer.sv
// MAZE node input-port buffer: queues packets with their route request and
// forks multi-direction heads across grant cycles before popping them.
module input_port_buffer
    import maze_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PLD_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input_port_buffer_if.slave     bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err_grant
);

    localparam int PKT_W = HDR_W + PLD_W;
    localparam int ENT_W = 5 + PKT_W;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [ENT_W-1:0] w_head;
    route_t           w_head_req;
    route_t           w_out_req;
    route_t           w_gnt;
    logic             w_bad_gnt;

    route_t           r_served;
    logic             r_err_grant;

    // Zero-request packets are consumed from upstream but never stored.
    assign bus.in_ready = !w_full;
    assign w_push       = bus.in_valid && !w_full && (bus.in_req != '0);

    assign w_head_req   = w_head[ENT_W-1 -: 5];
    assign w_out_req    = w_empty ? route_t'('0) : (w_head_req & ~r_served);
    assign bus.out_req  = w_out_req;
    assign bus.out_pkt  = w_head[PKT_W-1:0];

    assign w_gnt        = bus.grant & w_out_req;
    assign w_bad_gnt    = |(bus.grant & ~w_out_req);
    assign w_pop        = !w_empty && (w_gnt != '0) &&
                          route_done(w_head_req, r_served, w_gnt);
    assign err_grant    = r_err_grant;

    buf_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wr    (w_push),
        .i_wdata ({bus.in_req, bus.in_pkt}),
        .i_rd    (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_served    <= '0;
            r_err_grant <= 1'b0;
        end else begin
            if (w_pop) begin
                r_served <= '0;
            end else begin
                r_served <= r_served | w_gnt;
            end
            if (w_bad_gnt) begin
                r_err_grant <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_input_port_buffer.sv
// Self-checking bench for input_port_buffer: directed scenarios plus random
// traffic compared against a queue-based behavioural model.
module tb_input_port_buffer;
    import maze_pkg::*;

    localparam int DEPTH = 4;
    localparam int PLD_W = 32;
    localparam int PKT_W = HDR_W + PLD_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CNT_W-1:0] count;
    logic             err_grant;

    input_port_buffer_if #(.PLD_W(PLD_W)) bus ();

    input_port_buffer #(
        .DEPTH (DEPTH),
        .PLD_W (PLD_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .count     (count),
        .err_grant (err_grant)
    );

    always #5 clk = ~clk;

    logic [5+PKT_W-1:0] m_q[$];
    logic [4:0]         m_served;
    logic               m_err;
    int                 n_chk = 0;
    int                 n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] m_out_req();
        if (m_q.size() == 0) return 5'b0;
        return m_q[0][5+PKT_W-1 -: 5] & ~m_served;
    endfunction

    task automatic check_all(input string tag);
        logic [4:0] req;
        req = m_out_req();
        chk({tag, "_req"}, 64'(bus.out_req), 64'(req));
        chk({tag, "_rdy"}, 64'(bus.in_ready), 64'(m_q.size() < DEPTH));
        chk({tag, "_cnt"}, 64'(count), 64'(m_q.size()));
        chk({tag, "_err"}, 64'(err_grant), 64'(m_err));
        if (req != 5'b0) chk({tag, "_pkt"}, 64'(bus.out_pkt), 64'(m_q[0][PKT_W-1:0]));
    endtask

    function automatic logic [PKT_W-1:0] mkpkt(input logic [1:0] t, input logic [31:0] pld);
        logic [11:0] coords;
        coords = 12'($urandom);
        return {t, coords, pld};
    endfunction

    // One clock: drive inputs, advance the model, then check after the edge.
    task automatic cycle(input logic v, input logic [4:0] r, input logic [PKT_W-1:0] p,
                         input logic [4:0] g, input string tag);
        logic [4:0] mreq;
        logic [4:0] gg;
        logic       rdy;
        bus.in_valid = v;
        bus.in_req   = r;
        bus.in_pkt   = p;
        bus.grant    = g;
        mreq = m_out_req();
        rdy  = (m_q.size() < DEPTH);
        gg   = g & mreq;
        if ((g & ~mreq) != 5'b0) m_err = 1'b1;
        if (gg != 5'b0 && ((m_served | gg) == m_q[0][5+PKT_W-1 -: 5])) begin
            m_q.delete(0);
            m_served = 5'b0;
        end else begin
            m_served = m_served | gg;
        end
        if (v && rdy && r != 5'b0) m_q.push_back({r, p});
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        m_q.delete();
        m_served = 5'b0;
        m_err    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_req   = 5'b0;
        bus.in_pkt   = '0;
        bus.grant    = 5'b0;
        #1;
        chk({tag, "_async_req"}, 64'(bus.out_req), 64'd0);
        chk({tag, "_async_cnt"}, 64'(count), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [4:0] r;
        logic [4:0] g;
        do_reset("rst");
        chk("rst_ready", 64'(bus.in_ready), 64'd1);

        // Unicast east
        cycle(1'b1, 5'b01000, mkpkt(PKT_UNI, 32'hA5A5_0001), 5'b0, "t1_push");
        chk("t1_head", 64'(bus.out_req), 64'h08);
        cycle(1'b0, 5'b0, '0, 5'b01000, "t1_gnt");
        chk("t1_cnt0", 64'(count), 64'd0);
        chk("t1_noerr", 64'(err_grant), 64'd0);

        // Broadcast fork over three grant cycles
        cycle(1'b1, 5'b11111, mkpkt(PKT_BC, 32'hB0B0_0002), 5'b0, "t2_push");
        chk("t2_r0", 64'(bus.out_req), 64'h1F);
        cycle(1'b0, 5'b0, '0, 5'b00001, "t2_g0");
        chk("t2_r1", 64'(bus.out_req), 64'h1E);
        cycle(1'b0, 5'b0, '0, 5'b00110, "t2_g1");
        chk("t2_r2", 64'(bus.out_req), 64'h18);
        cycle(1'b0, 5'b0, '0, 5'b11000, "t2_g2");
        chk("t2_r3", 64'(bus.out_req), 64'h00);
        chk("t2_cnt", 64'(count), 64'd0);

        // Fill, stall, then drain one and let the held packet in
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 5'b00100, mkpkt(PKT_UNI, 32'(i + 16)), 5'b0, "t3_fill");
        chk("t3_full_cnt", 64'(count), 64'd4);
        chk("t3_full_rdy", 64'(bus.in_ready), 64'd0);
        cycle(1'b1, 5'b00010, mkpkt(PKT_UNI, 32'h55), 5'b0, "t3_stall");
        chk("t3_stall_cnt", 64'(count), 64'd4);
        cycle(1'b1, 5'b00010, mkpkt(PKT_UNI, 32'h55), 5'b00100, "t3_pop");
        chk("t3_pop_cnt", 64'(count), 64'd3);
        cycle(1'b1, 5'b00010, mkpkt(PKT_UNI, 32'h55), 5'b0, "t3_wr5");
        chk("t3_wr5_cnt", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++) cycle(1'b0, 5'b0, '0, 5'b00100, "t3_drain");
        cycle(1'b0, 5'b0, '0, 5'b00010, "t3_last");
        chk("t3_empty", 64'(count), 64'd0);

        // Ten sequential unicasts through the wrapping pointers
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 5'b01000, mkpkt(PKT_UNI, 32'(i)), 5'b0, "t4_push");
            chk("t4_pld", 64'(bus.out_pkt[31:0]), 64'(i));
            cycle(1'b0, 5'b0, '0, 5'b01000, "t4_pop");
        end
        chk("t4_cnt", 64'(count), 64'd0);

        // Zero request dropped; grant outside out_req flags an error
        cycle(1'b1, 5'b00000, mkpkt(PKT_UNI, 32'h77), 5'b0, "t5_zero");
        chk("t5_drop", 64'(count), 64'd0);
        cycle(1'b1, 5'b00100, mkpkt(PKT_UNI, 32'h78), 5'b0, "t5_push");
        cycle(1'b0, 5'b0, '0, 5'b00001, "t5_bad");
        chk("t5_err", 64'(err_grant), 64'd1);
        chk("t5_keep", 64'(count), 64'd1);
        cycle(1'b0, 5'b0, '0, 5'b00100, "t5_pop");
        chk("t5_sticky", 64'(err_grant), 64'd1);

        // Reset in the middle of a fork
        do_reset("t5_rst");
        cycle(1'b1, 5'b10101, mkpkt(PKT_COL, 32'h99), 5'b0, "t6_push");
        cycle(1'b1, 5'b00010, mkpkt(PKT_UNI, 32'h9A), 5'b00001, "t6_gN");
        chk("t6_part", 64'(bus.out_req), 64'h14);
        do_reset("t6_rst");
        chk("t6_empty", 64'(count), 64'd0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset("rnd_rst");
            r = ($urandom_range(0, 7) == 0) ? 5'b0 : 5'($urandom);
            if ($urandom_range(0, 99) == 0) g = 5'($urandom);
            else g = m_out_req() & 5'($urandom);
            cycle(1'($urandom), r, mkpkt(2'($urandom), $urandom), g, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
